ack_bus_rr_scheduler: RTL and testbench



---
 rtl/ack_bus_pkg.sv | 9 +
 rtl/rr_pick4.sv | 21 ++
 rtl/ack_bus_rr_scheduler.sv | 104 ++++++++++
 tb/tb_ack_bus_rr_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ack_bus_pkg.sv
// ack_bus_pkg: source IDs and scheduler state encoding shared by the ack bus arbiter.
package ack_bus_pkg;
    localparam int NUM_SRC = 4;
    localparam logic [1:0] ID_MEM  = 2'd0;
    localparam logic [1:0] ID_SHA  = 2'd1;
    localparam logic [1:0] ID_AES  = 2'd2;
    localparam logic [1:0] ID_CTRL = 2'd3;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotate-priority picker, scanning IDs ptr+1, ptr+2, ... mod 4.
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] id
);
    logic [1:0] start;
    logic [3:0] rot;
    logic [1:0] off;
    always_comb begin
        start = ptr + 2'd1;
        rot = start == 2'd0 ? eligible :
              start == 2'd1 ? {eligible[0], eligible[3:1]} :
              start == 2'd2 ? {eligible[1:0], eligible[3:2]} :
                              {eligible[2:0], eligible[3]};
        off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        valid = |eligible;
        id = start + off;
    end
endmodule

// File: rtl/ack_bus_rr_scheduler.sv
// ack_bus_rr_scheduler: round-robin ack bus owner with hold-until-drop, timeout release and turnaround gap.
module ack_bus_rr_scheduler
    import ack_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int GAP_CYCLES     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [1:0]         winner_id_o,
    output logic               ack_event_o,
    output logic               bus_valid_n_o,
    output logic               busy_o,
    output logic               timeout_o
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);

    state_t state, state_d;
    logic [NUM_SRC-1:0] grant_d, mask, mask_d, mask_set;
    logic [1:0] winner_d, rr_ptr, ptr_d, pick_id;
    logic [CW-1:0] cnt, cnt_d;
    logic [GW-1:0] gcnt, gcnt_d;
    logic pick_valid, ack_d, to_d;

    rr_pick4 u_pick (
        .eligible (req_i & ~mask),
        .ptr      (rr_ptr),
        .valid    (pick_valid),
        .id       (pick_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_o       <= '0;
            winner_id_o   <= ID_MEM;
            ack_event_o   <= 1'b0;
            bus_valid_n_o <= 1'b1;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
            rr_ptr        <= ID_CTRL;
            mask          <= '0;
            cnt           <= '0;
            gcnt          <= '0;
        end else begin
            state         <= state_d;
            grant_o       <= grant_d;
            winner_id_o   <= winner_d;
            ack_event_o   <= ack_d;
            bus_valid_n_o <= ~|grant_d;
            busy_o        <= state_d != IDLE;
            timeout_o     <= to_d;
            rr_ptr        <= ptr_d;
            mask          <= mask_d;
            cnt           <= cnt_d;
            gcnt          <= gcnt_d;
        end
    end

    // A drop on the expiry cycle wins over the timeout: normal release, no mask.
    always_comb begin
        state_d  = state;
        grant_d  = grant_o;
        winner_d = winner_id_o;
        ptr_d    = rr_ptr;
        ack_d    = 1'b0;
        to_d     = 1'b0;
        cnt_d    = cnt;
        gcnt_d   = gcnt;
        mask_set = '0;
        case (state)
            IDLE: if (pick_valid) begin
                state_d  = GRANT;
                grant_d  = 4'b0001 << pick_id;
                winner_d = pick_id;
                ptr_d    = pick_id;
                ack_d    = 1'b1;
                cnt_d    = '0;
            end
            GRANT: begin
                cnt_d = (TIMEOUT_CYCLES != 0 && cnt != CMAX) ? cnt + 1'b1 : cnt;
                if (!req_i[winner_id_o]) begin
                    state_d = GAP;
                    grant_d = '0;
                    gcnt_d  = '0;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CMAX) begin
                    state_d  = GAP;
                    grant_d  = '0;
                    gcnt_d   = '0;
                    to_d     = 1'b1;
                    mask_set = grant_o;
                end
            end
            GAP: if (gcnt == GMAX) state_d = IDLE; else gcnt_d = gcnt + 1'b1;
            default: state_d = IDLE;
        endcase
        mask_d = (mask & req_i) | mask_set;
    end
endmodule

// File: tb/tb_ack_bus_rr_scheduler.sv
// tb_ack_bus_rr_scheduler: directed checks of rotation, hold/release, gap, timeout/mask and async reset.
module tb_ack_bus_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] req0 = '0;
    logic [3:0] grant, grant0;
    logic [1:0] winner, winner0;
    logic ack, ack0, bvn, bvn0, busy, busy0, to, to0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ack_bus_rr_scheduler #(.TIMEOUT_CYCLES(16), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .grant_o(grant), .winner_id_o(winner),
        .ack_event_o(ack), .bus_valid_n_o(bvn), .busy_o(busy), .timeout_o(to)
    );

    ack_bus_rr_scheduler #(.TIMEOUT_CYCLES(0), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .grant_o(grant0), .winner_id_o(winner0),
        .ack_event_o(ack0), .bus_valid_n_o(bvn0), .busy_o(busy0), .timeout_o(to0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        int ng, nt;
        // reset values
        step(2);
        check("rst_grant", grant, 0);
        check("rst_winner", winner, 0);
        check("rst_ack", ack, 0);
        check("rst_bvn", bvn, 1);
        check("rst_busy", busy, 0);
        check("rst_to", to, 0);
        rst_n = 1'b1;

        // single AES request, release, one gap cycle
        req = 4'b0100;
        step(1);
        check("aes_grant", grant, 4'b0100);
        check("aes_winner", winner, 2);
        check("aes_ack", ack, 1);
        check("aes_bvn", bvn, 0);
        check("aes_busy", busy, 1);
        step(1);
        check("aes_ack_pulse", ack, 0);
        check("aes_hold", grant, 4'b0100);
        req = 4'b0000;
        step(1);
        check("aes_rel_grant", grant, 0);
        check("aes_rel_bvn", bvn, 1);
        check("aes_gap_busy", busy, 1);
        check("aes_gap_to", to, 0);
        step(1);
        check("aes_idle_busy", busy, 0);
        check("aes_idle_winner", winner, 2);

        // all four requesting: rotation 0,1,2,3,0 with two low cycles between grants
        do_reset();
        req = 4'b1111;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_grant%0d", i), grant, 4'b0001 << (i % 4));
            check($sformatf("rr_winner%0d", i), winner, i % 4);
            step(2);
            req[i % 4] = 1'b0;
            step(1);
            check($sformatf("rr_low1_%0d", i), grant, 0);
            req = 4'b1111;
            step(1);
            check($sformatf("rr_low2_%0d", i), grant, 0);
            step(1);
        end
        check("rr_after", grant, 4'b0010);
        req = 4'b0000;
        step(2);

        // timeout: MEM held, SHA waiting
        do_reset();
        req = 4'b0011;
        step(1);
        check("to_first", grant, 4'b0001);
        ng = 1;
        nt = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (grant == 4'b0001) ng++;
            if (to) nt++;
        end
        check("to_hold_cycles", ng, 16);
        check("to_no_early_pulse", nt, 0);
        step(1);
        check("to_release", grant, 0);
        check("to_pulse", to, 1);
        check("to_busy", busy, 1);
        step(1);
        check("to_pulse_end", to, 0);
        check("to_idle_low", grant, 0);
        step(1);
        check("to_sha_grant", grant, 4'b0010);
        check("to_sha_winner", winner, 1);
        req = 4'b0001;
        step(3);
        check("to_mem_masked", grant, 0);
        check("to_mem_masked_busy", busy, 0);
        req = 4'b0000;
        step(1);
        req = 4'b0001;
        step(1);
        check("to_mem_rewin", grant, 4'b0001);
        req = 4'b0000;
        step(3);

        // drop exactly on expiry cycle: plain release, no mask
        req = 4'b0100;
        step(1);
        check("edge_grant", grant, 4'b0100);
        step(15);
        check("edge_last_cycle", grant, 4'b0100);
        req = 4'b0000;
        step(1);
        check("edge_rel", grant, 0);
        check("edge_no_to", to, 0);
        req = 4'b0100;
        step(2);
        check("edge_not_masked", grant, 4'b0100);
        req = 4'b0000;
        step(3);

        // async reset in the first grant cycle
        req = 4'b1000;
        step(1);
        check("ar_grant", grant, 4'b1000);
        check("ar_ack", ack, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_grant_drop", grant, 0);
        check("ar_ack_drop", ack, 0);
        check("ar_bvn", bvn, 1);
        check("ar_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        check("ar_ctrl_grant", grant, 4'b1000);
        check("ar_ctrl_winner", winner, 3);
        do_reset();
        req = 4'b1001;
        step(1);
        check("ar_ptr_grant", grant, 4'b0001);
        check("ar_ptr_winner", winner, 0);
        req = 4'b0000;
        step(3);

        // timeout disabled: 100-cycle hold, no pulse
        req0 = 4'b0001;
        step(1);
        ng = 0;
        nt = 0;
        for (int k = 0; k < 100; k++) begin
            if (grant0 == 4'b0001) ng++;
            if (to0) nt++;
            step(1);
        end
        check("t0_hold", ng, 100);
        check("t0_no_pulse", nt, 0);
        check("t0_winner", winner0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
